// File: rtl/signed_divider_if.sv
// Handshake and data bundle for signed_divider: operands in, quotient/remainder/status out.
interface signed_divider_if;
    logic       start;
    logic [6:0] a;
    logic [3:0] b;
    logic [6:0] q;
    logic [3:0] r;
    logic       busy;
    logic       done;
    logic       err;

    modport master (output start, a, b, input q, r, busy, done, err);
    modport slave  (input start, a, b, output q, r, busy, done, err);
endinterface

// File: rtl/signed_divider.sv
// Sequential sign-magnitude restoring divider (7-bit / 4-bit), one quotient bit per clock.
// Optional macro SIGNED_DIVIDER_DBZ_EN: zero divisor finishes immediately with err=1.
module signed_divider (
    input  logic            clk,
    input  logic            rst_n,
    signed_divider_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state;
    logic [6:0] a_q;
    logic [3:0] b_q;
    logic [3:0] rem;
    logic [5:0] quo;
    logic [2:0] cnt;
    logic [6:0] q_r;
    logic [3:0] r_r;
    logic       busy_r;
    logic       done_r;
    logic [3:0] shifted;
    logic [3:0] rem_next;
    logic       q_bit;

    // cnt walks the dividend magnitude MSB first, so it doubles as the bit index
    always_comb begin
        shifted  = {rem[2:0], a_q[cnt]};
        q_bit    = (shifted >= {1'b0, b_q[2:0]});
        rem_next = q_bit ? (shifted - {1'b0, b_q[2:0]}) : shifted;
    end

`ifdef SIGNED_DIVIDER_DBZ_EN
    logic err_r;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            rem    <= '0;
            quo    <= '0;
            cnt    <= '0;
            q_r    <= '0;
            r_r    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
`ifdef SIGNED_DIVIDER_DBZ_EN
            err_r  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_q <= bus.a;
                        b_q <= bus.b;
                        rem <= '0;
                        quo <= '0;
                        cnt <= 3'd5;
`ifdef SIGNED_DIVIDER_DBZ_EN
                        if (bus.b[2:0] == 3'b000) begin
                            state  <= DONE;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            q_r    <= {bus.a[6] ^ bus.b[3], 6'h3F};
                            r_r    <= {bus.a[6], 3'b000};
                            err_r  <= 1'b1;
                        end else begin
                            state  <= RUN;
                            busy_r <= 1'b1;
                        end
`else
                        state  <= RUN;
                        busy_r <= 1'b1;
`endif
                    end else begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end
                end
                RUN: begin
                    rem <= rem_next;
                    quo <= {quo[4:0], q_bit};
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd0) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        q_r    <= {a_q[6] ^ b_q[3], quo[4:0], q_bit};
                        r_r    <= {a_q[6], rem_next[2:0]};
`ifdef SIGNED_DIVIDER_DBZ_EN
                        err_r  <= 1'b0;
`endif
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.q    = q_r;
    assign bus.r    = r_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
`ifdef SIGNED_DIVIDER_DBZ_EN
    assign bus.err  = err_r;
`else
    assign bus.err  = 1'b0;
`endif
endmodule

// File: tb/tb_signed_divider.sv
// Directed testbench for signed_divider with hand-computed quotient/remainder vectors.
module tb_signed_divider;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    signed_divider_if bus ();

    signed_divider dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives one start edge (edge 0) with the given operands, then drops start.
    task automatic issue(input logic [6:0] av, input logic [3:0] bv);
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Counts edges after the current point until done is seen, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (!bus.done && n < 30) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        tick();
        tick();
        rst_n = 1'b1;
        checks++;
        if ({bus.q, bus.r, bus.busy, bus.done, bus.err} !== 14'h0) begin
            errors++;
            $display("FAIL reset_outputs: got q=%h r=%h busy=%b done=%b err=%b, want all 0",
                     bus.q, bus.r, bus.busy, bus.done, bus.err);
        end
    endtask

    task automatic test_basic;
        issue(7'h15, 4'h3);
        for (int i = 0; i <= 5; i++) begin
            checks++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL basic_busy edge %0d: busy=%b done=%b, want busy=1 done=0", i, bus.busy, bus.done);
            end
            if (i < 5) tick();
        end
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_edge6: done=%b busy=%b, want done=1 busy=0", bus.done, bus.busy);
        end
        checks++;
        if (bus.q !== 7'h07 || bus.r !== 4'h0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: q=%h r=%h err=%b, want q=07 r=0 err=0", bus.q, bus.r, bus.err);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.q !== 7'h07 || bus.r !== 4'h0) begin
            errors++;
            $display("FAIL basic_hold: done=%b q=%h r=%h, want done=0 q=07 r=0", bus.done, bus.q, bus.r);
        end
    endtask

    task automatic test_negative;
        int n;
        issue(7'h55, 4'h4);
        wait_done(n);
        checks++;
        if (n + 1 != 7) begin
            errors++;
            $display("FAIL neg_latency: got %0d, want 7", n + 1);
        end
        checks++;
        if (bus.q !== 7'h45 || bus.r !== 4'h9) begin
            errors++;
            $display("FAIL neg_result: q=%h r=%h, want q=45 r=9", bus.q, bus.r);
        end
    endtask

    task automatic test_back_to_back;
        int n1;
        int n2;
        bus.a     = 7'h05;
        bus.b     = 4'h7;
        bus.start = 1'b1;
        tick();
        bus.a = 7'h31;
        bus.b = 4'hF;
        wait_done(n1);
        checks++;
        if (bus.done !== 1'b1 || bus.q !== 7'h00 || bus.r !== 4'h5) begin
            errors++;
            $display("FAIL b2b_first: done=%b q=%h r=%h, want done=1 q=00 r=5", bus.done, bus.q, bus.r);
        end
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_restart: busy=%b done=%b, want busy=1 done=0", bus.busy, bus.done);
        end
        wait_done(n2);
        checks++;
        if (n2 + 1 != 7) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d, want 7", n2 + 1);
        end
        checks++;
        if (bus.q !== 7'h47 || bus.r !== 4'h0) begin
            errors++;
            $display("FAIL b2b_second: q=%h r=%h, want q=47 r=0", bus.q, bus.r);
        end
    endtask

    task automatic test_div_zero;
        int n;
        issue(7'h15, 4'h8);
        wait_done(n);
`ifdef SIGNED_DIVIDER_DBZ_EN
        checks++;
        if (n + 1 != 1) begin
            errors++;
            $display("FAIL dbz_latency: got %0d, want 1", n + 1);
        end
        checks++;
        if (bus.q !== 7'h7F || bus.r !== 4'h0 || bus.err !== 1'b1) begin
            errors++;
            $display("FAIL dbz_result: q=%h r=%h err=%b, want q=7F r=0 err=1", bus.q, bus.r, bus.err);
        end
`else
        checks++;
        if (n + 1 != 7) begin
            errors++;
            $display("FAIL dbz_latency: got %0d, want 7", n + 1);
        end
        checks++;
        if (bus.q !== 7'h7F || bus.r !== 4'h5 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL dbz_result: q=%h r=%h err=%b, want q=7F r=5 err=0", bus.q, bus.r, bus.err);
        end
`endif
        tick();
    endtask

    task automatic test_ignore_start;
        int n;
        issue(7'h15, 4'h3);
        tick();
        tick();
        bus.a     = 7'h55;
        bus.b     = 4'h4;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(n);
        checks++;
        if (n + 4 != 7) begin
            errors++;
            $display("FAIL ignore_latency: got %0d, want 7", n + 4);
        end
        checks++;
        if (bus.q !== 7'h07 || bus.r !== 4'h0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL ignore_result: q=%h r=%h err=%b, want q=07 r=0 err=0", bus.q, bus.r, bus.err);
        end
        tick();
    endtask

    task automatic test_mid_reset;
        int  n;
        logic saw_done;
        issue(7'h55, 4'h4);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({bus.q, bus.r, bus.busy, bus.done, bus.err} !== 14'h0) begin
            errors++;
            $display("FAIL midreset_outputs: q=%h r=%h busy=%b done=%b err=%b, want all 0",
                     bus.q, bus.r, bus.busy, bus.done, bus.err);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle: activity=%b after reset, want 0", saw_done);
        end
        issue(7'h15, 4'h3);
        wait_done(n);
        checks++;
        if (n + 1 != 7 || bus.q !== 7'h07 || bus.r !== 4'h0) begin
            errors++;
            $display("FAIL midreset_rerun: latency=%0d q=%h r=%h, want 7 q=07 r=0", n + 1, bus.q, bus.r);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_back_to_back();
        test_div_zero();
        test_ignore_start();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
